// File: rtl/fetch_queue_if.sv
// Fetch-queue bus: instruction-memory request/response, redirect, and the
// instruction delivery handshake. The queue is the master side; the
// memory/consumer environment is the slave side.
interface fetch_queue_if #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic [31:0]     imem_rdata;
  logic            redirect;
  logic [XLEN-1:0] redirect_pc;
  logic            inst_valid;
  logic            inst_ready;
  logic [31:0]     inst;
  logic [XLEN-1:0] inst_pc;
  logic [CW-1:0]   count;

  modport master (
    output imem_req, imem_addr, inst_valid, inst, inst_pc, count,
    input  imem_rdata, redirect, redirect_pc, inst_ready
  );

  modport slave (
    input  imem_req, imem_addr, inst_valid, inst, inst_pc, count,
    output imem_rdata, redirect, redirect_pc, inst_ready
  );
endinterface

// File: rtl/fetch_queue.sv
// Instruction fetch unit with a small in-order instruction queue.
// Issues one word fetch per cycle while queue credit allows, captures the
// response one cycle later, and hands instructions to the consumer through a
// valid/ready handshake. A redirect flushes the queue, squashes the in-flight
// response and restarts fetching at the (word-aligned) target.
// Optional feature: define FETCH_BYPASS_EN to let a response arriving at an
// empty queue be presented to the consumer in the same cycle.
module fetch_queue #(
  parameter int              XLEN     = 32,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic         clk,
  input  logic         rst,
  fetch_queue_if.master bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] resp_pc;
  logic            resp_pending;

  logic [31:0]     q_inst [DEPTH];
  logic [XLEN-1:0] q_pc   [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [CW-1:0]   cnt;

  logic            q_empty;
  logic            resp_live;
  logic            push;
  logic            pop_q;
  logic            req;
  logic [CW:0]     next_occ;

  assign bus.imem_req  = req;
  assign bus.imem_addr = fetch_pc;
  assign bus.count     = cnt;

  // Handshake, credit and output-mux decisions for the current cycle.
  always_comb begin
    q_empty        = (cnt == '0);
    resp_live      = resp_pending && !bus.redirect;
    bus.inst_valid = !q_empty;
    bus.inst       = q_inst[rd_ptr];
    bus.inst_pc    = q_pc[rd_ptr];
    push           = resp_live;
`ifdef FETCH_BYPASS_EN
    // Empty queue: the arriving word is shown directly and only lands in the
    // queue when the consumer does not take it this cycle.
    if (q_empty && resp_live) begin
      bus.inst_valid = 1'b1;
      bus.inst       = bus.imem_rdata;
      bus.inst_pc    = resp_pc;
      push           = !bus.inst_ready;
    end
`endif
    pop_q    = !q_empty && bus.inst_ready;
    // Occupancy after this cycle's push/pop; the response pushed now is the
    // one that was in flight, so a new request needs one more free slot.
    next_occ = (CW+1)'(cnt) + (CW+1)'(push) - (CW+1)'(pop_q);
    req      = rst && !bus.redirect && (next_occ < (CW+1)'(DEPTH));
  end

  // Fetch PC and in-flight request tracking.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc     <= RESET_PC;
      resp_pc      <= '0;
      resp_pending <= 1'b0;
    end else begin
      resp_pending <= req;
      if (req) resp_pc <= fetch_pc;
      if (bus.redirect) fetch_pc <= {bus.redirect_pc[XLEN-1:2], 2'b00};
      else if (req)     fetch_pc <= fetch_pc + XLEN'(4);
    end
  end

  // Instruction queue storage, pointers and occupancy.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        q_inst[i] <= '0;
        q_pc[i]   <= '0;
      end
    end else if (bus.redirect) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) begin
        q_inst[wr_ptr] <= bus.imem_rdata;
        q_pc[wr_ptr]   <= resp_pc;
        wr_ptr         <= wr_ptr + 1'b1;
      end
      if (pop_q) rd_ptr <= rd_ptr + 1'b1;
      cnt <= next_occ[CW-1:0];
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Testbench for fetch_queue: directed scenarios plus randomized traffic,
// checked by a scoreboard of expected {pc, word} pairs and an expected
// request-address tracker.
module tb_fetch_queue;
  localparam int          XLEN     = 32;
  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0;

  logic clk = 1'b0;
  logic rst = 1'b0;

  fetch_queue_if #(.XLEN(XLEN), .DEPTH(DEPTH)) bus ();

  fetch_queue #(.XLEN(XLEN), .DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] pc; logic [31:0] data; } exp_t;
  exp_t        sbq[$];
  logic [31:0] exp_req;
  int          checks = 0;
  int          passes = 0;
  int          req40  = 0;

  function automatic logic [31:0] mem_f(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h00000013;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Reference stream: after a restart the consumer must see consecutive words
  // from the aligned target, and the memory must be asked for the same run.
  task automatic refill(input logic [31:0] target);
    logic [31:0] t;
    t = target & 32'hFFFF_FFFC;
    sbq.delete();
    for (int i = 0; i < 200; i++) begin
      exp_t e;
      e.pc   = t + 32'(4 * i);
      e.data = mem_f(e.pc);
      sbq.push_back(e);
    end
    exp_req = t;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_redirect(input logic [31:0] pc);
    bus.redirect    = 1'b1;
    bus.redirect_pc = pc;
    step();
    bus.redirect = 1'b0;
    refill(pc);
  endtask

  // Instruction memory: answers a request one cycle later, junk otherwise.
  initial begin
    logic        r;
    logic [31:0] a;
    bus.imem_rdata = '0;
    forever begin
      @(negedge clk);
      r = bus.imem_req && rst;
      a = bus.imem_addr;
      @(posedge clk);
      #1;
      bus.imem_rdata = r ? mem_f(a) : $urandom;
    end
  end

  // Monitor: delivered instructions and issued requests against the model.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        if (bus.inst_valid && bus.inst_ready) begin
          if (sbq.size() == 0) check("sb_underflow", 1, 0);
          else begin
            e = sbq.pop_front();
            check("inst_pc", bus.inst_pc, e.pc);
            check("inst", bus.inst, e.data);
          end
        end
        if (bus.redirect) check("req_during_redirect", bus.imem_req, 0);
        else if (bus.imem_req) begin
          if (bus.imem_addr == 32'h40) req40++;
          check("req_addr", bus.imem_addr, exp_req);
          exp_req = exp_req + 32'd4;
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1);
  end

  initial begin
    int first, hs, nreq, k, n;
    bus.redirect    = 1'b0;
    bus.redirect_pc = '0;
    bus.inst_ready  = 1'b0;
    refill(RESET_PC);
    repeat (3) step();

    // Reset state
    check("rst_imem_req", bus.imem_req, 0);
    check("rst_inst_valid", bus.inst_valid, 0);
    check("rst_inst", bus.inst, 0);
    check("rst_inst_pc", bus.inst_pc, 0);
    check("rst_count", bus.count, 0);
    check("rst_imem_addr", bus.imem_addr, RESET_PC);

    // Release: latency and sustained throughput
    bus.inst_ready = 1'b1;
    rst = 1'b1;
    first = -1;
    for (int c = 0; c < 8; c++) begin
      #1;
      if (first < 0 && bus.inst_valid) first = c;
      step();
    end
`ifdef FETCH_BYPASS_EN
    check("first_valid_latency", first, 1);
`else
    check("first_valid_latency", first, 2);
`endif
    hs = 0;
    for (int c = 0; c < 10; c++) begin
      if (bus.inst_valid && bus.inst_ready) hs++;
      step();
    end
    check("throughput_10", hs, 10);

    // Back-pressure: queue fills to DEPTH and requests stop
    bus.inst_ready = 1'b0;
    do_redirect(32'h0);
    nreq = 0;
    for (int c = 0; c < 10; c++) begin
      #1;
      if (bus.imem_req) nreq++;
      step();
    end
    check("stall_requests", nreq, DEPTH);
    check("stall_count", bus.count, DEPTH);
    check("stall_no_req", bus.imem_req, 0);
    bus.inst_ready = 1'b1;
    repeat (10) step();

    // Redirect with count=3 and a response in flight
    bus.inst_ready = 1'b0;
    do_redirect(32'h200);
    k = 0;
    while (bus.count != 3 && k < 12) begin step(); k++; end
    check("fill_to_3", bus.count, 3);
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'h103;
    step();
    bus.redirect = 1'b0;
    refill(32'h103);
    #1;
    check("flush_count", bus.count, 0);
    check("flush_valid", bus.inst_valid, 0);
    check("flush_addr", bus.imem_addr, 32'h100);
    bus.inst_ready = 1'b1;
    repeat (10) step();

    // Address wrap
    do_redirect(32'hFFFF_FFF8);
    check("wrap_a0", bus.imem_addr, 32'hFFFF_FFF8);
    step();
    check("wrap_a1", bus.imem_addr, 32'hFFFF_FFFC);
    step();
    check("wrap_a2", bus.imem_addr, 32'h0000_0000);
    repeat (8) step();

    // Back-to-back redirects: last one wins
    req40 = 0;
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'h40;
    step();
    bus.redirect_pc = 32'h80;
    step();
    bus.redirect = 1'b0;
    refill(32'h80);
    repeat (10) step();
    check("no_fetch_0x40", req40, 0);

    // Reset pulse mid-stream with count=2
    bus.inst_ready = 1'b0;
    do_redirect(32'h300);
    k = 0;
    while (bus.count != 2 && k < 12) begin step(); k++; end
    check("fill_to_2", bus.count, 2);
    rst = 1'b0;
    refill(RESET_PC);
    #1;
    check("mid_rst_req", bus.imem_req, 0);
    check("mid_rst_valid", bus.inst_valid, 0);
    check("mid_rst_inst", bus.inst, 0);
    check("mid_rst_pc", bus.inst_pc, 0);
    check("mid_rst_count", bus.count, 0);
    step();
    rst = 1'b1;
    #1;
    check("rel_addr", bus.imem_addr, RESET_PC);
    check("rel_req", bus.imem_req, 1);
    bus.inst_ready = 1'b1;
    repeat (10) step();

    // Randomized traffic
    for (int it = 0; it < 25; it++) begin
      bus.inst_ready = ($urandom_range(0, 3) != 0);
      do_redirect($urandom);
      n = $urandom_range(5, 30);
      for (int c = 0; c < n; c++) begin
        bus.inst_ready = ($urandom_range(0, 3) != 0);
        if ($urandom_range(0, 11) == 0) do_redirect($urandom);
        else step();
      end
    end
    bus.inst_ready = 1'b1;
    repeat (10) step();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
